sb_arbiter_rr: RTL and testbench



---
 rtl/sb_pkg.sv | 50 +++++
 rtl/sb_rr_picker.sv | 34 +++
 rtl/sb_arbiter_rr.sv | 120 ++++++++++++
 tb/tb_sb_arbiter_rr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared encodings and helpers for the system-bus arbiter family.
// Transfer/burst/response codes match the bus wire encodings.
package sb_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } trans_t;

   typedef enum logic [2:0] {
      BURST_SINGLE = 3'b000,
      BURST_INCR   = 3'b001,
      BURST_WRAP4  = 3'b010,
      BURST_INCR4  = 3'b011,
      BURST_WRAP8  = 3'b100,
      BURST_INCR8  = 3'b101,
      BURST_WRAP16 = 3'b110,
      BURST_INCR16 = 3'b111
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01,
      RESP_RETRY = 2'b10,
      RESP_SPLIT = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      ST_FREE   = 2'b00,
      ST_BURST  = 2'b01,
      ST_LOCKED = 2'b10
   } arb_state_t;

   localparam int BEAT_CNT_W = 4;

   // Remaining beats after the NONSEQ; zero means the burst is not counted.
   function automatic logic [BEAT_CNT_W-1:0] burst_beats_m1(input logic [2:0] burst);
      logic [BEAT_CNT_W-1:0] n;
      casez (burst)
         3'b01?:  n = 4'd3;
         3'b10?:  n = 4'd7;
         3'b11?:  n = 4'd15;
         default: n = 4'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sb_rr_picker.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping.
// Purely combinational; no flow control.
module sb_rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         vld
);

   always_comb begin
      int j;
      logic [W-1:0] pos;
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      j   = 0;
      pos = '0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         pos = W'(j);
         if (!vld && req[pos]) begin
            vld      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/sb_arbiter_rr.sv
// N-master round-robin bus arbiter with lock, counted-burst hold and split masking.
// Grant registered one cycle after decision; owner follows grant on the next ready cycle.
module sb_arbiter_rr
   import sb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int MASTER_W       = $clog2(NUM_MASTERS),
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   sb_clk,
   input  logic                   sb_resetn,
   input  logic [NUM_MASTERS-1:0] sb_busreq,
   input  logic [NUM_MASTERS-1:0] sb_lock,
   input  logic [1:0]             sb_trans_ar,
   input  logic [2:0]             sb_burst_ar,
   input  logic [1:0]             sb_resp_ar,
   input  logic                   sb_ready_ar,
   input  logic [NUM_MASTERS-1:0] sb_split_ar,
   output logic [NUM_MASTERS-1:0] sb_grant,
   output logic [MASTER_W-1:0]    sb_masters,
   output logic                   sb_mastlock
);

   localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MASTER_W-1:0]    DEF_IDX = MASTER_W'(DEFAULT_MASTER);

   arb_state_t             state_q, state_d;
   logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] mask_q, mask_d, split_set;
   logic [MASTER_W-1:0]    gnt_idx_q, gnt_idx_d, rr_start, pick_idx;
   logic [NUM_MASTERS-1:0] grant_d, pick_gnt;
   logic                   pick_vld, owner_hold;
   trans_t                 trans;
   resp_t                  resp;

   assign trans      = trans_t'(sb_trans_ar);
   assign resp       = resp_t'(sb_resp_ar);
   assign owner_hold = sb_lock[gnt_idx_q] & sb_busreq[gnt_idx_q];
   assign rr_start   = (gnt_idx_q == MASTER_W'(NUM_MASTERS - 1)) ? '0
                                                                 : gnt_idx_q + MASTER_W'(1);

   sb_rr_picker #(.N(NUM_MASTERS), .W(MASTER_W)) u_picker (
      .req (sb_busreq & ~mask_q),
      .ptr (rr_start),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .vld (pick_vld)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FREE: begin
            if (owner_hold) begin
               state_d = ST_LOCKED;
            end else if (sb_ready_ar && trans == TRANS_NONSEQ &&
                         burst_beats_m1(sb_burst_ar) != '0) begin
               state_d = ST_BURST;
               cnt_d   = burst_beats_m1(sb_burst_ar);
            end
         end
         ST_BURST: begin
            // IDLE or any non-OKAY response aborts the burst early
            if (trans == TRANS_IDLE || resp != RESP_OKAY) begin
               state_d = ST_FREE;
               cnt_d   = '0;
            end else if (sb_ready_ar && trans == TRANS_SEQ) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) state_d = ST_FREE;
            end
         end
         ST_LOCKED: begin
            if (resp == RESP_SPLIT || (sb_ready_ar && !owner_hold)) state_d = ST_FREE;
         end
         default: state_d = ST_FREE;
      endcase
   end

   // Set wins over a release pulse on the same bit.
   assign split_set = (resp == RESP_SPLIT && !sb_ready_ar) ? (NUM_MASTERS'(1) << sb_masters) : '0;
   assign mask_d    = (mask_q & ~sb_split_ar) | split_set;

   always_comb begin
      grant_d   = sb_grant;
      gnt_idx_d = gnt_idx_q;
      if (state_d == ST_FREE) begin
         if (pick_vld) begin
            grant_d   = pick_gnt;
            gnt_idx_d = pick_idx;
         end else begin
            grant_d   = DEF_GNT;
            gnt_idx_d = DEF_IDX;
         end
      end
   end

   always_ff @(posedge sb_clk or negedge sb_resetn) begin
      if (!sb_resetn) begin
         state_q     <= ST_FREE;
         cnt_q       <= '0;
         mask_q      <= '0;
         gnt_idx_q   <= DEF_IDX;
         sb_grant    <= DEF_GNT;
         sb_masters  <= DEF_IDX;
         sb_mastlock <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         gnt_idx_q <= gnt_idx_d;
         sb_grant  <= grant_d;
         if (sb_ready_ar) begin
            sb_masters  <= gnt_idx_q;
            sb_mastlock <= sb_lock[gnt_idx_q];
         end
      end
   end

endmodule

// File: tb/tb_sb_arbiter_rr.sv
// Scoreboard bench for sb_arbiter_rr with a 4-master reference model.
module tb_sb_arbiter_rr;
   import sb_pkg::*;

   localparam int N = 4;

   logic         sb_clk = 1'b0;
   logic         sb_resetn;
   logic [N-1:0] sb_busreq, sb_lock, sb_split_ar;
   logic [1:0]   sb_trans_ar, sb_resp_ar;
   logic [2:0]   sb_burst_ar;
   logic         sb_ready_ar;
   logic [N-1:0] sb_grant;
   logic [1:0]   sb_masters;
   logic         sb_mastlock;

   sb_arbiter_rr #(.NUM_MASTERS(N), .MASTER_W(2), .DEFAULT_MASTER(0)) dut (
      .sb_clk      (sb_clk),
      .sb_resetn   (sb_resetn),
      .sb_busreq   (sb_busreq),
      .sb_lock     (sb_lock),
      .sb_trans_ar (sb_trans_ar),
      .sb_burst_ar (sb_burst_ar),
      .sb_resp_ar  (sb_resp_ar),
      .sb_ready_ar (sb_ready_ar),
      .sb_split_ar (sb_split_ar),
      .sb_grant    (sb_grant),
      .sb_masters  (sb_masters),
      .sb_mastlock (sb_mastlock)
   );

   always #5 sb_clk = ~sb_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct packed {
      logic [N-1:0] g;
      logic [1:0]   m;
      logic         l;
   } exp_t;
   exp_t sbq[$];

   // Reference model state: granted index, fsm (0 free,1 burst,2 locked), beats left, mask, owner
   int           mg, ms, mc, mown;
   logic [N-1:0] mmask;
   logic         mlock;

   task automatic model_reset();
      mg = 0; ms = 0; mc = 0; mown = 0; mmask = '0; mlock = 1'b0;
   endtask

   task automatic model_step();
      int g_n, s_n, c_n;
      logic [N-1:0] mask_n, elig;
      bit hold;
      hold = sb_lock[mg] && sb_busreq[mg];
      s_n = ms;
      c_n = mc;
      if (ms == 0) begin
         if (hold) s_n = 2;
         else if (sb_ready_ar && sb_trans_ar == 2'b10 && sb_burst_ar[2:1] != 2'b00) begin
            s_n = 1;
            c_n = (2 << sb_burst_ar[2:1]) - 1;
         end
      end else if (ms == 1) begin
         if (sb_trans_ar == 2'b00 || sb_resp_ar != 2'b00) begin
            s_n = 0; c_n = 0;
         end else if (sb_ready_ar && sb_trans_ar == 2'b11) begin
            c_n = mc - 1;
            if (c_n == 0) s_n = 0;
         end
      end else begin
         if (sb_resp_ar == 2'b11 || (sb_ready_ar && !hold)) s_n = 0;
      end
      mask_n = mmask & ~sb_split_ar;
      if (sb_resp_ar == 2'b11 && !sb_ready_ar) mask_n[mown] = 1'b1;
      g_n = mg;
      if (s_n == 0) begin
         elig = sb_busreq & ~mmask;
         g_n  = 0;
         for (int k = N; k >= 1; k--) if (elig[(mg + k) % N]) g_n = (mg + k) % N;
      end
      if (sb_ready_ar) begin
         mown  = mg;
         mlock = sb_lock[mg];
      end
      mg = g_n; ms = s_n; mc = c_n; mmask = mask_n;
   endtask

   task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                      input logic [2:0] bu, input logic [1:0] rs, input logic rdy,
                      input logic [N-1:0] sp);
      exp_t e;
      sb_busreq = req; sb_lock = lk; sb_trans_ar = tr; sb_burst_ar = bu;
      sb_resp_ar = rs; sb_ready_ar = rdy; sb_split_ar = sp;
      model_step();
      e.g = 4'b0001 << mg;
      e.m = 2'(mown);
      e.l = mlock;
      sbq.push_back(e);
      @(posedge sb_clk);
      #1;
      e = sbq.pop_front();
      check("grant", 32'(sb_grant), 32'(e.g));
      check("masters", 32'(sb_masters), 32'(e.m));
      check("mastlock", 32'(sb_mastlock), 32'(e.l));
      check("onehot", 32'($onehot(sb_grant)), 32'd1);
   endtask

   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
   localparam logic [1:0] OK = 2'b00, SPL = 2'b11;

   initial begin
      logic [N-1:0] rot [4];
      logic [1:0]   beats [9];
      rot   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      beats = '{SEQ, SEQ, BUSY, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ};

      sb_resetn = 1'b1;
      sb_busreq = '0; sb_lock = '0; sb_split_ar = '0;
      sb_trans_ar = IDLE; sb_burst_ar = 3'b000; sb_resp_ar = OK; sb_ready_ar = 1'b0;
      model_reset();
      #2 sb_resetn = 1'b0;
      #10;
      check("rst_grant", 32'(sb_grant), 32'h1);
      check("rst_masters", 32'(sb_masters), 32'h0);
      check("rst_mastlock", 32'(sb_mastlock), 32'h0);
      sb_resetn = 1'b1;

      // idle: default master keeps the bus
      repeat (2) cyc(4'b0000, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      check("idle_grant", 32'(sb_grant), 32'h1);

      // round robin over all four requesters
      for (int i = 0; i < 4; i++) begin
         cyc(4'b1111, 4'b0000, NSQ, 3'b000, OK, 1'b1, 4'b0000);
         check("rotate", 32'(sb_grant), 32'(rot[i]));
      end

      // INCR8 by master 2 with master 1 waiting
      cyc(4'b0110, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      cyc(4'b0110, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      check("burst_setup", 32'(sb_grant), 32'h4);
      cyc(4'b0110, 4'b0000, NSQ, 3'b101, OK, 1'b1, 4'b0000);
      check("burst_start", 32'(sb_grant), 32'h4);
      for (int i = 0; i < 9; i++) begin
         cyc(4'b0110, 4'b0000, beats[i], 3'b101, OK, 1'b1, 4'b0000);
         check("burst_beat", 32'(sb_grant), (i < 8) ? 32'h4 : 32'h2);
      end

      // master 3 locked for five transfers, then lock dropped
      for (int i = 1; i <= 7; i++) begin
         cyc(4'b1111, 4'b1000, NSQ, 3'b000, OK, 1'b1, 4'b0000);
         if (i >= 2) check("lock_grant", 32'(sb_grant), 32'h8);
         if (i >= 3) check("lock_mastlock", 32'(sb_mastlock), 32'h1);
      end
      cyc(4'b1111, 4'b0000, NSQ, 3'b000, OK, 1'b1, 4'b0000);
      check("unlock_grant", 32'(sb_grant), 32'h1);
      check("unlock_mastlock", 32'(sb_mastlock), 32'h0);

      // split: master 1 owner, masked, released, then set and clear together
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      check("split_owner", 32'(sb_masters), 32'h1);
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, SPL, 1'b0, 4'b0000);
      check("split_mask_set", 32'(dut.mask_q[1]), 32'h1);
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, SPL, 1'b1, 4'b0000);
      check("split_default", 32'(sb_grant), 32'h1);
      repeat (4) begin
         cyc(4'b0111, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
         check("split_excl", 32'(sb_grant[1]), 32'h0);
      end
      cyc(4'b0111, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0010);
      check("split_release", 32'(dut.mask_q[1]), 32'h0);
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      check("split_rejoin", 32'(sb_grant), 32'h2);
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      cyc(4'b0010, 4'b0000, IDLE, 3'b000, SPL, 1'b0, 4'b0010);
      check("split_set_wins", 32'(dut.mask_q[1]), 32'h1);
      cyc(4'b0111, 4'b0000, IDLE, 3'b000, SPL, 1'b1, 4'b0000);
      repeat (3) begin
         cyc(4'b0111, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
         check("split_excl2", 32'(sb_grant[1]), 32'h0);
      end

      // async reset in the middle of an INCR16
      cyc(4'b1111, 4'b0000, NSQ, 3'b111, OK, 1'b1, 4'b0000);
      repeat (3) cyc(4'b1111, 4'b0000, SEQ, 3'b111, OK, 1'b1, 4'b0000);
      check("pre_rst_state", 32'(dut.state_q), 32'(ST_BURST));
      #3 sb_resetn = 1'b0;
      #1;
      check("arst_grant", 32'(sb_grant), 32'h1);
      check("arst_masters", 32'(sb_masters), 32'h0);
      check("arst_mastlock", 32'(sb_mastlock), 32'h0);
      check("arst_cnt", 32'(dut.cnt_q), 32'h0);
      check("arst_state", 32'(dut.state_q), 32'(ST_FREE));
      model_reset();
      @(posedge sb_clk);
      #1 sb_resetn = 1'b1;
      repeat (2) cyc(4'b0100, 4'b0000, IDLE, 3'b000, OK, 1'b1, 4'b0000);
      check("post_rst_grant", 32'(sb_grant), 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
